// File: rtl/alu_compute_pipe.sv
// alu_compute_pipe: two-stage pipelined saturating EX-stage ALU with valid/ready handshake, flush and flag register
module alu_compute_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE = 4,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] offset,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [WIDTH-1:0] out_addr,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       flag
);
  localparam int NL = WIDTH / LANE;
  localparam int NB = WIDTH / 8;
  localparam int LSW = NL * (LANE + 1);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_SW = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [3:0]       s1_op_q, s1_op_d, s2_op_q, s2_op_d;
  logic [WIDTH:0]   s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0] s1_misc_q, s1_misc_d, s1_addr_q, s1_addr_d;
  logic [WIDTH-1:0] s2_addr_q, s2_addr_d, s2_res_q, s2_res_d;
  logic [LSW-1:0]   s1_lane_q, s1_lane_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic [2:0]       flag_q, flag_d;
  logic             adv1, adv2, acc, ld2, handoff, ovf;
  logic [WIDTH-1:0] red, sra, ror, sat, pad;
  logic [LSW-1:0]   lanes;
  logic [LANE:0]    ls;
  logic [2:0]       nvz;

  always_comb begin
    adv2 = !s2_v_q || out_ready;
    adv1 = !s1_v_q || adv2;
    acc = in_valid && adv1 && !flush_i;
    ld2 = s1_v_q && adv2 && !flush_i;
    handoff = s2_v_q && out_ready && !flush_i;
    red = '0;
    for (int i = 0; i < NB; i++)
      red = red + {{(WIDTH-8){in_a[8*i+7]}}, in_a[8*i+:8]} + {{(WIDTH-8){in_b[8*i+7]}}, in_b[8*i+:8]};
    lanes = '0;
    for (int l = 0; l < NL; l++)
      lanes[l*(LANE+1)+:LANE+1] = {in_a[l*LANE+LANE-1], in_a[l*LANE+:LANE]} + {in_b[l*LANE+LANE-1], in_b[l*LANE+:LANE]};
    sra = $signed(in_a) >>> shamt;
    ror = (in_a >> shamt) | (in_a << (WIDTH - int'(shamt)));
    s1_v_d = flush_i ? 1'b0 : adv1 ? in_valid : s1_v_q;
    s1_op_d = acc ? opcode : s1_op_q;
    s1_sum_d = !acc ? s1_sum_q :
               opcode == OP_SUB ? {in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b} :
               {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
    s1_addr_d = acc ? {in_a[WIDTH-1:1], 1'b0} + {offset[WIDTH-2:0], 1'b0} : s1_addr_q;
    s1_lane_d = acc ? lanes : s1_lane_q;
    s1_misc_d = !acc ? s1_misc_q :
                opcode == OP_XOR ? in_a ^ in_b :
                opcode == OP_RED ? red :
                opcode == OP_SLL ? in_a << shamt :
                opcode == OP_SRA ? sra :
                opcode == OP_ROR ? ror :
                opcode == OP_SW  ? in_b :
                opcode == OP_LLB ? {in_a[WIDTH-1:8], offset[7:0]} :
                opcode == OP_LHB ? {offset[7:0], in_a[WIDTH-9:0]} : '0;
  end

  always_comb begin
    ovf = s1_sum_q[WIDTH] ^ s1_sum_q[WIDTH-1];
    sat = ovf ? {s1_sum_q[WIDTH], {(WIDTH-1){~s1_sum_q[WIDTH]}}} : s1_sum_q[WIDTH-1:0];
    pad = '0;
    ls = '0;
    for (int l = 0; l < NL; l++) begin
      ls = s1_lane_q[l*(LANE+1)+:LANE+1];
      pad[l*LANE+:LANE] = (ls[LANE] ^ ls[LANE-1]) ? {ls[LANE], {(LANE-1){~ls[LANE]}}} : ls[LANE-1:0];
    end
    s2_v_d = flush_i ? 1'b0 : adv2 ? s1_v_q : s2_v_q;
    s2_op_d = ld2 ? s1_op_q : s2_op_q;
    s2_addr_d = ld2 ? s1_addr_q : s2_addr_q;
    s2_ovf_d = ld2 ? ovf : s2_ovf_q;
    s2_res_d = !ld2 ? s2_res_q :
               (s1_op_q == OP_ADD || s1_op_q == OP_SUB) ? sat :
               s1_op_q == OP_PADDSB ? pad : s1_misc_q;
    nvz = {s2_res_q[WIDTH-1], s2_ovf_q, s2_res_q == '0};
    flag_d = !handoff ? flag_q :
             (s2_op_q == OP_ADD || s2_op_q == OP_SUB) ? nvz :
             (s2_op_q == OP_XOR || s2_op_q == OP_SLL || s2_op_q == OP_SRA || s2_op_q == OP_ROR) ? {flag_q[2:1], nvz[0]} :
             flag_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_op_q <= '0;
      s2_op_q <= '0;
      s1_sum_q <= '0;
      s1_misc_q <= '0;
      s1_addr_q <= '0;
      s1_lane_q <= '0;
      s2_addr_q <= '0;
      s2_res_q <= '0;
      s2_ovf_q <= 1'b0;
      flag_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_op_q <= s1_op_d;
      s2_op_q <= s2_op_d;
      s1_sum_q <= s1_sum_d;
      s1_misc_q <= s1_misc_d;
      s1_addr_q <= s1_addr_d;
      s1_lane_q <= s1_lane_d;
      s2_addr_q <= s2_addr_d;
      s2_res_q <= s2_res_d;
      s2_ovf_q <= s2_ovf_d;
      flag_q <= flag_d;
    end

  assign in_ready = adv1;
  assign out_valid = s2_v_q;
  assign out_opcode = s2_op_q;
  assign out_addr = s2_addr_q;
  assign out_result = s2_res_q;
  assign flag = flag_q;
endmodule

// File: tb/tb_alu_compute_pipe.sv
// tb_alu_compute_pipe: scoreboard bench with directed and randomized beats checked against a behavioural ALU model
module tb_alu_compute_pipe;
  localparam int W = 16;
  localparam int LANE = 4;
  localparam int SHW = $clog2(W);

  logic clk = 0, rst_n = 1, flush_i = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [3:0] opcode = 0, out_opcode;
  logic [W-1:0] in_a = 0, in_b = 0, offset = 0, out_addr, out_result;
  logic [SHW-1:0] shamt = 0;
  logic [2:0] flag;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] addr;
    logic [W-1:0] res;
    logic [2:0]   we;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t me;
  logic [2:0] mflag = 0;
  logic [W-1:0] last_res = 0, last_addr = 0;
  int n_cmp = 0, n_bad = 0;
  bit rand_ready = 0;

  always #5 clk = ~clk;

  alu_compute_pipe #(.WIDTH(W), .LANE(LANE), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_a(in_a), .in_b(in_b), .offset(offset), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_addr(out_addr), .out_result(out_result), .flag(flag)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sv(input longint u, input int bits);
    return u >= (longint'(1) << (bits - 1)) ? u - (longint'(1) << bits) : u;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] off, input logic [SHW-1:0] sh);
    exp_t e;
    longint s, d, mx, mn, lmx, lmn;
    logic [W-1:0] r;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -(longint'(1) << (W - 1));
    lmx = (longint'(1) << (LANE - 1)) - 1;
    lmn = -(longint'(1) << (LANE - 1));
    e.op = op;
    e.res = '0;
    e.we = 3'b000;
    e.v = 1'b0;
    e.addr = W'((longint'(a) / 2) * 2 + longint'(off) * 2);
    case (op)
      4'd0, 4'd1: begin
        s = sv(longint'(a), W) + (op == 4'd0 ? sv(longint'(b), W) : -sv(longint'(b), W));
        e.v = s > mx || s < mn;
        s = s > mx ? mx : s < mn ? mn : s;
        e.res = W'(s);
        e.we = 3'b111;
      end
      4'd2: begin e.res = a ^ b; e.we = 3'b001; end
      4'd3: begin
        s = 0;
        for (int i = 0; i < W / 8; i++) s += sv(longint'(a[8*i+:8]), 8) + sv(longint'(b[8*i+:8]), 8);
        e.res = W'(s);
      end
      4'd4: begin e.res = W'(longint'(a) * (longint'(1) << sh)); e.we = 3'b001; end
      4'd5: begin
        s = sv(longint'(a), W);
        d = longint'(1) << sh;
        e.res = W'(s >= 0 ? s / d : -((-s + d - 1) / d));
        e.we = 3'b001;
      end
      4'd6: begin
        r = a;
        for (int k = 0; k < int'(sh); k++) r = {r[0], r[W-1:1]};
        e.res = r;
        e.we = 3'b001;
      end
      4'd7: for (int l = 0; l < W / LANE; l++) begin
        s = sv(longint'(a[l*LANE+:LANE]), LANE) + sv(longint'(b[l*LANE+:LANE]), LANE);
        s = s > lmx ? lmx : s < lmn ? lmn : s;
        e.res[l*LANE+:LANE] = LANE'(s);
      end
      4'd9: e.res = b;
      4'd10: e.res = {a[W-1:8], off[7:0]};
      4'd11: e.res = {off[7:0], a[W-9:0]};
      default: e.res = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("flag_model", W'(flag), W'(mflag));
      if (flush_i) q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_beat: got result %0h with empty scoreboard", out_result);
          end else begin
            me = q.pop_front();
            chk("opcode", W'(out_opcode), W'(me.op));
            chk("addr", out_addr, me.addr);
            chk("result", out_result, me.res);
            mflag = (mflag & ~me.we) | ({me.res[W-1], me.v, me.res == '0} & me.we);
            last_res = out_result;
            last_addr = out_addr;
          end
        end
        if (in_valid && in_ready) q.push_back(model(opcode, in_a, in_b, offset, shamt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] off, input logic [SHW-1:0] sh);
    bit ok;
    int n;
    n = 0;
    opcode = op; in_a = a; in_b = b; offset = off; shamt = sh; in_valid = 1;
    do begin
      @(negedge clk);
      ok = in_ready && !flush_i;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: op %0h got in_ready 0 expected 1 within 200 cycles", op);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1;
    @(posedge clk);
    #1;
    flush_i = 0;
  endtask

  task automatic one(input string nm, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] off, input logic [SHW-1:0] sh, input logic [W-1:0] exp);
    send(op, a, b, off, sh);
    drain();
    chk(nm, last_res, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, k, n;
    #1 rst_n = 0;
    #2;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_flag", W'(flag), 0);
    chk("rst_result", out_result, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_opcode", W'(out_opcode), 0);
    @(posedge clk);
    #1 rst_n = 1;

    send(4'd0, 16'h7000, 16'h2000, 0, 0);
    n = 0;
    while (!out_valid && n < 2) begin @(posedge clk); #1; n++; end
    chk("t1_latency_valid", W'(out_valid), 1);
    drain();
    chk("t1_add_sat", last_res, 16'h7FFF);
    chk("t1_flag", W'(flag), 16'h2);

    one("t2_sub", 4'd1, 16'h0005, 16'h0005, 0, 0, 16'h0000);
    chk("t2_sub_flag", W'(flag), 16'h1);
    one("t2_xor", 4'd2, 16'h8000, 16'h8000, 0, 0, 16'h0000);
    chk("t2_xor_flag", W'(flag), 16'h1);
    one("t2_add_negsat", 4'd0, 16'h8000, 16'hFFFF, 0, 0, 16'h8000);
    chk("t2_add_flag", W'(flag), 16'h6);

    one("t3_paddsb", 4'd7, 16'h7878, 16'h1111, 0, 0, 16'h7979);
    one("t3_red_pos", 4'd3, 16'h0102, 16'h0304, 0, 0, 16'h000A);
    one("t3_red_neg", 4'd3, 16'h8080, 16'h8080, 0, 0, 16'hFE00);
    one("t3_ror", 4'd6, 16'h0001, 0, 0, 1, 16'h8000);
    one("t3_sw_data", 4'd9, 16'h1003, 16'hBEEF, 16'h0004, 0, 16'hBEEF);
    chk("t3_sw_addr", last_addr, 16'h100A);
    chk("t3_flag_kept", W'(flag), 16'h6);

    out_ready = 0;
    acc = 0;
    k = 1;
    for (int c = 0; c < 4; c++) begin
      opcode = 4'd0; in_a = W'(k); in_b = W'(k); offset = 0; shamt = 0; in_valid = 1;
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
      @(posedge clk);
      #1;
    end
    chk("t4_accepted", W'(acc), 2);
    chk("t4_in_ready_low", W'(in_ready), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t4_hold_valid", W'(out_valid), 1);
    chk("t4_hold_result", out_result, 16'd2);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stream_valid", W'(out_valid), 1);
      @(posedge clk);
      #1;
      in_valid = 0;
    end
    drain();
    chk("t4_last", last_res, 16'd6);

    one("t5_setup", 4'd0, 16'h7000, 16'h2000, 0, 0, 16'h7FFF);
    out_ready = 0;
    send(4'd0, 16'd10, 16'd1, 0, 0);
    send(4'd0, 16'd20, 16'd2, 0, 0);
    do_flush();
    chk("t5_valid_cleared", W'(out_valid), 0);
    chk("t5_flag_kept", W'(flag), 16'h2);
    chk("t5_in_ready", W'(in_ready), 1);
    out_ready = 1;
    send(4'd0, 16'd5, 16'd6, 0, 0);
    n = 0;
    while (!out_valid && n < 2) begin @(posedge clk); #1; n++; end
    chk("t5_next_valid", W'(out_valid), 1);
    drain();
    chk("t5_next_result", last_res, 16'd11);
    chk("t5_flag_after", W'(flag), 16'h0);

    one("t6_setup", 4'd0, 16'h7000, 16'h2000, 0, 0, 16'h7FFF);
    out_ready = 0;
    send(4'd0, 16'd1, 16'd1, 0, 0);
    send(4'd0, 16'd2, 16'd2, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_valid", W'(out_valid), 0);
    chk("t6_rst_flag", W'(flag), 0);
    chk("t6_rst_result", out_result, 0);
    q.delete();
    mflag = 0;
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    one("t6_add", 4'd0, 16'd3, 16'd4, 0, 0, 16'h0007);
    chk("t6_flag", W'(flag), 16'h0);

    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      int sa, sb;
      sa = $urandom_range(0, 7);
      sb = $urandom_range(0, 7);
      a = sa == 0 ? 16'h7FFF : sa == 1 ? 16'h8000 : sa == 2 ? 16'h0000 : W'($urandom);
      b = sb == 0 ? 16'h7FFF : sb == 1 ? 16'h8000 : sb == 2 ? 16'hFFFF : W'($urandom);
      send(4'($urandom_range(0, 15)), a, b, W'($urandom), SHW'($urandom));
      if ($urandom_range(0, 29) == 0) do_flush();
      if ($urandom_range(0, 4) == 0) tick();
    end
    rand_ready = 0;
    drain();
    chk("final_scoreboard_empty", W'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
